// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_tx_serializer: tick-timed UART frame serializer (start/data/parity/stop)
// Revision: 1.0
// ============================================================================
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tick,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_tick_en,
  output logic                 o_tick_clr
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] C_TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] C_STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick_en_q, tick_en_d;
  logic                 tick_clr_q, tick_clr_d;
  logic                 bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tick_en_q  <= 1'b0;
      tick_clr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tick_en_q  <= tick_en_d;
      tick_clr_q <= tick_clr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tick_en_d  = tick_en_q;
    tick_clr_d = 1'b0;
    bit_end    = 1'b0;

    // Ticks only count once a frame is under way; the accept cycle never counts.
    if (state_q != S_IDLE && i_tick) begin
      if (tick_cnt_q == C_TICK_LAST) begin
        tick_cnt_d = '0;
        bit_end    = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_valid && ready_q) begin
          shreg_d    = i_data;
          par_d      = (PARITY_ODD != 0) ? ~^i_data : ^i_data;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_START;
          tx_d       = 1'b0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          tick_en_d  = 1'b1;
          tick_clr_d = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == C_DATA_LAST) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == C_STOP_LAST) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            tick_en_d = 1'b0;
            ready_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_ready    = ready_q;
  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_tick_en  = tick_en_q;
  assign o_tick_clr = tick_clr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_tx_serializer: three configured serializers, line-decoding scoreboard
// Revision: 1.0
// ============================================================================
module tb_uart_tx_serializer;

  localparam int N = 3;

  typedef struct {
    int          id;
    logic [11:0] bits;
    int          n;
    bit          timed;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid [N];
  logic [7:0] data  [N];
  logic       hold  [N];
  logic       ready [N];
  logic       tx    [N];
  logic       busy  [N];
  logic       done  [N];
  logic       ten   [N];
  logic       tclr  [N];
  logic       tick  [N];
  int         pops  [N] = '{0, 0, 0};
  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++)
      if (!rst && valid[k] && ready[k]) pops[k] <= pops[k] + 1;
  end

  // id0: 8N1, id1: even parity + 2 stop bits, id2: odd parity
  uart_tx_serializer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .i_tick(tick[0]), .i_valid(valid[0]), .i_data(data[0]), .o_ready(ready[0]),
    .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]), .o_tick_en(ten[0]), .o_tick_clr(tclr[0]));
  uart_tx_serializer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .i_tick(tick[1]), .i_valid(valid[1]), .i_data(data[1]), .o_ready(ready[1]),
    .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]), .o_tick_en(ten[1]), .o_tick_clr(tclr[1]));
  uart_tx_serializer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .i_tick(tick[2]), .i_valid(valid[2]), .i_data(data[2]), .o_ready(ready[2]),
    .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]), .o_tick_en(ten[2]), .o_tick_clr(tclr[2]));

  // Tick generator model: one tick every 4 clk, restarted by tick_clr.
  for (genvar g = 0; g < N; g++) begin : g_tick
    logic [1:0] div;
    always_ff @(posedge clk) begin
      if (!ten[g] || tclr[g]) div <= 2'd0;
      else                    div <= div + 2'd1;
    end
    assign tick[g] = ten[g] && !tclr[g] && !hold[g] && (div == 2'd3);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [7:0] d, input bit timed);
    exp_t e;
    int   pe, ns;
    pe      = (id != 0) ? 1 : 0;
    ns      = (id == 1) ? 2 : 1;
    e.id    = id;
    e.timed = timed;
    e.bits  = '1;
    e.bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) e.bits[k+1] = d[k];
    if (pe != 0) e.bits[9] = (id == 2) ? ~^d : ^d;
    e.n = 9 + pe + ns;
    return e;
  endfunction

  // Decodes the line by sampling mid-bit (8th of 16 ticks), checks on o_done.
  task automatic monitor(input int id);
    logic [11:0] cap = '1;
    int          nb = 0, tc = 0, t0 = 0, nclr = 0, k;
    bit          act = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0;
      end else begin
        if (!act && busy[id]) begin
          act = 1'b1; cap = '1; nb = 0; tc = 0; t0 = cyc; nclr = 0;
        end
        if (act) begin
          if (tclr[id]) nclr++;
          if (tick[id]) begin
            tc++;
            if (tc % 16 == 8 && nb < 12) begin
              cap[nb] = tx[id];
              nb++;
            end
          end
        end
        if (done[id]) begin
          chk($sformatf("done_in_frame[%0d]", id), act, 1);
          act = 1'b0;
          k = -1;
          for (int j = 0; j < sb.size(); j++)
            if (sb[j].id == id) begin k = j; break; end
          chk($sformatf("frame_expected[%0d]", id), k >= 0, 1);
          if (k >= 0) begin
            e = sb[k];
            sb.delete(k);
            chk($sformatf("frame_bits[%0d]", id), cap, e.bits);
            chk($sformatf("frame_nbits[%0d]", id), nb, e.n);
            chk($sformatf("tick_clr_pulses[%0d]", id), nclr, 1);
            if (e.timed) chk_rng($sformatf("frame_clks[%0d]", id), cyc - t0, e.n*64 - 1, e.n*64 + 1);
          end
        end
      end
    end
  endtask

  task automatic send(input int id, input logic [7:0] d, input bit expect_frame, input bit timed);
    int w = 0;
    if (expect_frame) sb.push_back(mk(id, d, timed));
    valid[id] = 1'b1;
    data[id]  = d;
    while (!ready[id] && w < 4000) begin @(negedge clk); w++; end
    chk("accept_wait", w < 4000, 1);
    @(negedge clk);
    valid[id] = 1'b0;
  endtask

  task automatic wait_done(input int id);
    int w = 0;
    while (!done[id] && w < 4000) begin @(negedge clk); w++; end
    chk("done_wait", w < 4000, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    for (int k = 0; k < N; k++) begin valid[k] = 1'b0; data[k] = 8'h00; hold[k] = 1'b0; end
    rst = 1'b1;
    fork monitor(0); monitor(1); monitor(2); join_none
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("rst_tx", tx[k], 1);
      chk("rst_ready", ready[k], 1);
      chk("rst_busy", busy[k], 0);
    end
    chk("rst_done", done[0], 0);
    chk("rst_tick_en", ten[0], 0);
    chk("rst_tick_clr", tclr[0], 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send(0, 8'h55, 1, 1);
    wait_done(0);
    send(1, 8'h07, 1, 1);
    wait_done(1);
    send(2, 8'h07, 1, 1);
    wait_done(2);

    // Back-to-back with valid held high, two stop bits
    p = pops[1];
    sb.push_back(mk(1, 8'hA3, 1));
    sb.push_back(mk(1, 8'h3C, 1));
    valid[1] = 1'b1; data[1] = 8'hA3;
    @(negedge clk);
    data[1] = 8'h3C;
    wait_done(1);
    chk("b2b_ready_at_done", ready[1], 1);
    chk("b2b_busy_at_done", busy[1], 0);
    @(negedge clk);
    chk("b2b_start_tx", tx[1], 0);
    chk("b2b_busy", busy[1], 1);
    chk("b2b_ready_low", ready[1], 0);
    valid[1] = 1'b0;
    wait_done(1);
    chk("b2b_pops", pops[1] - p, 2);

    // Tick stall holds the start bit
    hold[0] = 1'b1;
    send(0, 8'h5A, 1, 0);
    repeat (300) @(negedge clk);
    chk("stall_tx", tx[0], 0);
    chk("stall_busy", busy[0], 1);
    hold[0] = 1'b0;
    wait_done(0);

    // Input activity mid-frame must be ignored
    p = pops[0];
    send(0, 8'hC6, 1, 1);
    repeat (200) @(negedge clk);
    chk("mid_ready", ready[0], 0);
    valid[0] = 1'b1; data[0] = 8'hFF;
    @(negedge clk);
    valid[0] = 1'b0; data[0] = 8'h00;
    wait_done(0);
    chk("mid_pops", pops[0] - p, 1);

    // Async reset during data bit 3 of 0x96 (bit 3 = 0)
    send(0, 8'h96, 0, 0);
    repeat (276) @(negedge clk);
    chk("pre_rst_tx", tx[0], 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx", tx[0], 1);
    chk("arst_busy", busy[0], 0);
    chk("arst_ready", ready[0], 1);
    chk("arst_done", done[0], 0);
    chk("arst_tick_en", ten[0], 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (800) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
